// File: rtl/uart_tx_controller.sv
// Bulk-message UART transmitter: buffers {addr,data} messages in a small FIFO and
// sends each one as 8N1 frames, address byte first, then data bytes MSB byte first.
module uart_tx_controller #(
    parameter int DATA_WIDTH     = 32,
    parameter int MSG_FIFO_DEPTH = 4,
    parameter int UART_BAUD_RATE = 115200,
    parameter int CLK_FREQ       = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  bulk_tx_valid,
    output logic                  bulk_tx_ready,
    input  logic [7:0]            bulk_tx_addr,
    input  logic [DATA_WIDTH-1:0] bulk_tx_data,
    output logic                  uart_txd,
    output logic                  busy
);

    // state | meaning
    // IDLE  | line idle, waiting for a buffered message
    // LOAD  | pick the next byte of the message (one cycle)
    // START | start bit (low) for PULSE_WIDTH cycles
    // DATA  | eight data bits, LSB first
    // STOP  | stop bit (high), then next byte / next message / idle
    localparam int NBYTES      = DATA_WIDTH / 8;
    localparam int MSG_W       = 8 + DATA_WIDTH;
    localparam int PULSE_WIDTH = CLK_FREQ / UART_BAUD_RATE;
    localparam int TW          = $clog2(PULSE_WIDTH + 1);
    localparam int AW          = $clog2(MSG_FIFO_DEPTH);
    localparam int IW          = $clog2(NBYTES + 1);

    localparam logic [TW-1:0] PW_LAST   = TW'(PULSE_WIDTH - 1);
    localparam logic [IW-1:0] LAST_BYTE = IW'(NBYTES);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    state_t            state;
    logic [MSG_W-1:0]  mem [MSG_FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [MSG_W-1:0]  shift_msg;
    logic [7:0]        shift_byte;
    logic [IW-1:0]     byte_idx;
    logic [2:0]        bit_idx;
    logic [TW-1:0]     timer;
    logic              empty, full, push, pop, timer_done;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty         = (wr_ptr == rd_ptr);
    assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign bulk_tx_ready = !full;
    assign push          = bulk_tx_valid && !full;
    assign timer_done    = (timer == PW_LAST);
    assign pop           = !empty && ((state == IDLE) ||
                           (state == STOP && timer_done && byte_idx == LAST_BYTE));

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= {bulk_tx_addr, bulk_tx_data};
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            shift_msg  <= '0;
            shift_byte <= '0;
            byte_idx   <= '0;
            bit_idx    <= '0;
            timer      <= '0;
            uart_txd   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            busy <= (state != IDLE) || !empty;
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (pop) begin
                        shift_msg <= mem[rd_ptr[AW-1:0]];
                        byte_idx  <= '0;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // Message is consumed from the top, so the next byte is always the MSBs.
                    shift_byte <= shift_msg[MSG_W-1 -: 8];
                    shift_msg  <= shift_msg << 8;
                    uart_txd   <= 1'b0;
                    timer      <= '0;
                    state      <= START;
                end
                START: begin
                    if (timer_done) begin
                        timer    <= '0;
                        bit_idx  <= '0;
                        uart_txd <= shift_byte[0];
                        state    <= DATA;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                DATA: begin
                    if (timer_done) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            uart_txd <= 1'b1;
                            state    <= STOP;
                        end else begin
                            bit_idx    <= bit_idx + 3'd1;
                            uart_txd   <= shift_byte[1];
                            shift_byte <= {1'b0, shift_byte[7:1]};
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                STOP: begin
                    if (timer_done) begin
                        timer <= '0;
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + IW'(1);
                            state    <= LOAD;
                        end else if (pop) begin
                            shift_msg <= mem[rd_ptr[AW-1:0]];
                            byte_idx  <= '0;
                            state     <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    uart_txd <= 1'b1;
                    timer    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_controller.sv
// Directed bench for uart_tx_controller at PULSE_WIDTH = 1_000_000/125_000 = 8 cycles,
// so one 5-byte message lasts 5*(10*8+1) = 405 cycles.
module tb_uart_tx_controller;

    localparam int PW      = 8;
    localparam int MSG_LEN = 405;

    logic        clk = 1'b0;
    logic        rstn;
    logic        bulk_tx_valid;
    logic        bulk_tx_ready;
    logic [7:0]  bulk_tx_addr;
    logic [31:0] bulk_tx_data;
    logic        uart_txd;
    logic        busy;

    int cyc = 0;
    int n_assert = 0;
    int n_fail = 0;

    uart_tx_controller #(
        .DATA_WIDTH(32), .MSG_FIFO_DEPTH(4), .UART_BAUD_RATE(125_000), .CLK_FREQ(1_000_000)
    ) dut (
        .clk(clk), .rstn(rstn),
        .bulk_tx_valid(bulk_tx_valid), .bulk_tx_ready(bulk_tx_ready),
        .bulk_tx_addr(bulk_tx_addr), .bulk_tx_data(bulk_tx_data),
        .uart_txd(uart_txd), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Called at a negedge; returns the posedge index of the accepting edge.
    task automatic push(input logic [7:0] a, input logic [31:0] d, output int pc);
        int g = 0;
        bulk_tx_addr  = a;
        bulk_tx_data  = d;
        bulk_tx_valid = 1'b1;
        while (bulk_tx_ready !== 1'b1 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        bulk_tx_valid = 1'b0;
        pc = cyc;
    endtask

    // Waits for a start bit, then samples every bit at its centre.
    task automatic get_byte(output logic [7:0] b, output logic st, output logic sp,
                            output int fall, output bit to);
        int g = 0;
        to = 1'b0;
        while (uart_txd !== 1'b0 && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) to = 1'b1;
        fall = cyc;
        repeat (PW/2) @(negedge clk);
        st = uart_txd;
        for (int i = 0; i < 8; i++) begin
            repeat (PW) @(negedge clk);
            b[i] = uart_txd;
        end
        repeat (PW) @(negedge clk);
        sp = uart_txd;
    endtask

    task automatic recv_msg(output logic [7:0] b [5], output logic [4:0] st,
                            output logic [4:0] sp, output int fall0, output bit to);
        logic [7:0] bb;
        logic s0, s1;
        int f;
        bit t;
        to = 1'b0;
        fall0 = 0;
        for (int k = 0; k < 5; k++) begin
            get_byte(bb, s0, s1, f, t);
            b[k] = bb;
            st[k] = s0;
            sp[k] = s1;
            if (k == 0) fall0 = f;
            if (t) to = 1'b1;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bulk_tx_valid = 1'b0;
        bulk_tx_addr = '0;
        bulk_tx_data = '0;
        repeat (3) @(negedge clk);
        n_assert++;
        if (uart_txd !== 1'b1 || bulk_tx_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: txd=%b ready=%b busy=%b, want 1 1 0", uart_txd, bulk_tx_ready, busy);
        end
        rstn = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n_assert++;
            if (uart_txd !== 1'b1 || bulk_tx_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_cycle_%0d: txd=%b ready=%b busy=%b, want 1 1 0", i, uart_txd, bulk_tx_ready, busy);
            end
        end
    endtask

    task automatic test_single();
        logic [7:0] exp [5];
        logic [7:0] b [5];
        logic [4:0] st, sp;
        int pc, f, g;
        bit to;
        exp = '{8'h32, 8'h01, 8'h23, 8'h45, 8'h67};
        push(8'h32, 32'h01234567, pc);
        recv_msg(b, st, sp, f, to);
        n_assert++;
        if (to) begin n_fail++; $display("FAIL single_timeout: no start bit seen"); end
        for (int k = 0; k < 5; k++) begin
            n_assert++;
            if (b[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL single_byte%0d: got %h want %h", k, b[k], exp[k]);
            end
        end
        n_assert++;
        if (st !== 5'b00000 || sp !== 5'b11111) begin
            n_fail++;
            $display("FAIL single_framing: start=%b stop=%b want 00000 11111", st, sp);
        end
        n_assert++;
        if (f - pc !== 2) begin
            n_fail++;
            $display("FAIL single_latency: fall-push=%0d want 2", f - pc);
        end
        g = 0;
        while (busy !== 1'b0 && g < 2000) begin @(negedge clk); g++; end
        n_assert++;
        if (cyc - f !== MSG_LEN) begin
            n_fail++;
            $display("FAIL single_duration: busy drop at %0d after fall, want %0d", cyc - f, MSG_LEN);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  ma [5];
        logic [31:0] md [5];
        logic [7:0]  rb [5][5];
        logic [4:0]  rst_bits [5];
        logic [4:0]  rsp_bits [5];
        int          falls [5];
        bit          tos [5];
        logic [7:0]  e;
        int push1 = 0;
        int rise = 0;
        ma = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
        md = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3, 32'hE0E1E2E3};
        fork
            begin
                int i = 0;
                int g = 0;
                logic r;
                bulk_tx_valid = 1'b1;
                while (i < 5 && g < 2000) begin
                    bulk_tx_addr = ma[i];
                    bulk_tx_data = md[i];
                    r = bulk_tx_ready;
                    @(negedge clk);
                    g++;
                    if (r) begin
                        if (i == 0) push1 = cyc;
                        i++;
                    end
                end
                bulk_tx_valid = 1'b0;
                n_assert++;
                if (i != 5 || bulk_tx_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL b2b_full: accepted=%0d ready=%b, want 5 and 0", i, bulk_tx_ready);
                end
                g = 0;
                while (bulk_tx_ready !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
                rise = cyc;
                n_assert++;
                if (rise - push1 !== 2 + MSG_LEN - 1) begin
                    n_fail++;
                    $display("FAIL b2b_ready_rise: %0d cycles after push1, want %0d", rise - push1, 2 + MSG_LEN - 1);
                end
            end
            begin
                for (int m = 0; m < 5; m++) begin
                    logic [7:0] tb5 [5];
                    recv_msg(tb5, rst_bits[m], rsp_bits[m], falls[m], tos[m]);
                    for (int k = 0; k < 5; k++) rb[m][k] = tb5[k];
                end
            end
        join
        n_assert++;
        if (falls[0] - push1 !== 2) begin
            n_fail++;
            $display("FAIL b2b_latency: fall-push=%0d want 2", falls[0] - push1);
        end
        for (int m = 0; m < 5; m++) begin
            n_assert++;
            if (tos[m] || rst_bits[m] !== 5'b00000 || rsp_bits[m] !== 5'b11111) begin
                n_fail++;
                $display("FAIL b2b_framing_msg%0d: timeout=%0d start=%b stop=%b", m, tos[m], rst_bits[m], rsp_bits[m]);
            end
            for (int k = 0; k < 5; k++) begin
                e = (k == 0) ? ma[m] : md[m][39 - 8*k -: 8];
                n_assert++;
                if (rb[m][k] !== e) begin
                    n_fail++;
                    $display("FAIL b2b_msg%0d_byte%0d: got %h want %h", m, k, rb[m][k], e);
                end
            end
            if (m > 0) begin
                n_assert++;
                if (falls[m] - falls[m-1] !== MSG_LEN) begin
                    n_fail++;
                    $display("FAIL b2b_gap_msg%0d: spacing %0d want %0d", m, falls[m] - falls[m-1], MSG_LEN);
                end
            end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_extremes();
        logic [7:0] exp0 [5];
        logic [7:0] exp1 [5];
        logic [7:0] b0 [5];
        logic [7:0] b1 [5];
        logic [4:0] st0, sp0, st1, sp1;
        int pc0, pc1, f0, f1;
        bit to0, to1;
        exp0 = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        exp1 = '{8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        push(8'hFF, 32'h00000000, pc0);
        push(8'h00, 32'hFFFFFFFF, pc1);
        recv_msg(b0, st0, sp0, f0, to0);
        recv_msg(b1, st1, sp1, f1, to1);
        n_assert++;
        if (to0 || to1) begin n_fail++; $display("FAIL ext_timeout: %0d %0d", to0, to1); end
        for (int k = 0; k < 5; k++) begin
            n_assert++;
            if (b0[k] !== exp0[k] || b1[k] !== exp1[k]) begin
                n_fail++;
                $display("FAIL ext_byte%0d: got %h/%h want %h/%h", k, b0[k], b1[k], exp0[k], exp1[k]);
            end
        end
        n_assert++;
        if (st0 !== 5'b0 || st1 !== 5'b0 || sp0 !== 5'b11111 || sp1 !== 5'b11111) begin
            n_fail++;
            $display("FAIL ext_framing: start=%b,%b stop=%b,%b", st0, st1, sp0, sp1);
        end
        n_assert++;
        if (f1 - f0 !== MSG_LEN) begin
            n_fail++;
            $display("FAIL ext_gap: spacing %0d want %0d", f1 - f0, MSG_LEN);
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] exp [5];
        logic [7:0] b [5];
        logic [4:0] st, sp;
        int pa, pb, pc, f, g;
        bit to;
        bit bad = 1'b0;
        exp = '{8'h5A, 8'hC3, 8'h3C, 8'h96, 8'h69};
        push(8'h32, 32'h01234567, pa);
        push(8'hAA, 32'h55AA55AA, pb);
        // byte 2 (0x23) bit 2 is low from F+186 to F+194, F = pa+2
        g = 0;
        while (cyc < pa + 2 + 190 && g < 2000) begin @(negedge clk); g++; end
        n_assert++;
        if (uart_txd !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_pre_txd: got %b want 0", uart_txd);
        end
        #2 rstn = 1'b0;
        #1;
        n_assert++;
        if (uart_txd !== 1'b1 || busy !== 1'b0 || bulk_tx_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_async: txd=%b busy=%b ready=%b want 1 0 1", uart_txd, busy, bulk_tx_ready);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        n_assert++;
        if (bad) begin
            n_fail++;
            $display("FAIL rst_flush: line or busy active after reset, txd=%b busy=%b want 1 0", uart_txd, busy);
        end
        push(8'h5A, 32'hC33C9669, pc);
        recv_msg(b, st, sp, f, to);
        n_assert++;
        if (to || st !== 5'b0 || sp !== 5'b11111 || f - pc !== 2) begin
            n_fail++;
            $display("FAIL rst_after_frame: timeout=%0d start=%b stop=%b latency=%0d", to, st, sp, f - pc);
        end
        for (int k = 0; k < 5; k++) begin
            n_assert++;
            if (b[k] !== exp[k]) begin
                n_fail++;
                $display("FAIL rst_after_byte%0d: got %h want %h", k, b[k], exp[k]);
            end
        end
        repeat (20) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_extremes();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
